// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding word-aligned memory access with lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of aligning them down.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic        in_wen,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             wen_q;

  logic [1:0]       off_c;
  logic [31:0]      wdata_c;
  logic [7:0]       wmask_c;
  logic             trap_c;

  // Effective lane offset: halves align to 2 bytes, words to 4.
  always_comb begin
    off_c   = 2'b00;
    wdata_c = in_wdata;
    wmask_c = 8'h0F;
    case (in_size)
      2'b00: begin
        off_c   = in_addr[1:0];
        wdata_c = {4{in_wdata[7:0]}};
        wmask_c = 8'(8'h01 << in_addr[1:0]);
      end
      2'b01: begin
        off_c   = {in_addr[1], 1'b0};
        wdata_c = {2{in_wdata[15:0]}};
        wmask_c = 8'(8'h03 << {in_addr[1], 1'b0});
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_c = ((in_size == 2'b01) && in_addr[0]) ||
                  (in_size[1] && (in_addr[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = raw >> {off, 3'b000};
    case (size)
      2'b00:   extend = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   extend = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      wen_q         <= 1'b0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_rdata     <= 32'h0;
      out_fault     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            off_q     <= off_c;
            size_q    <= in_size;
            uns_q     <= in_unsigned;
            wen_q     <= in_wen;
            mem_addr  <= {in_addr[31:2], 2'b00};
            mem_wen   <= in_wen;
            mem_wdata <= wdata_c;
            mem_wmask <= in_wen ? wmask_c : 8'h00;
            if (trap_c) begin
              out_valid <= 1'b1;
              out_fault <= 1'b1;
              out_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A response in the final counted cycle still wins over the timeout.
          if (mem_resp_valid) begin
            out_rdata <= wen_q ? 32'h0 : extend(mem_resp_rdata, off_q, size_q, uns_q);
            out_fault <= 1'b0;
            out_valid <= 1'b1;
            state     <= RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
            out_rdata <= 32'h0;
            out_fault <= 1'b1;
            out_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-lane reference model.
module tb_lsu_mem_ctrl;

  localparam int unsigned TMO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen, in_unsigned;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        out_valid, out_ready, out_fault;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mem_ctrl #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wen(in_wen),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the access covers n consecutive byte lanes starting at the aligned-down offset.
  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                       input logic uns, input logic [31:0] rd,
                       output logic [31:0] ewdata, output logic [7:0] emask,
                       output logic [31:0] eload, output bit trap);
    int n, off, base;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    base = (off / n) * n;
    trap = TRAP && (off != base);
    emask = 8'h00;
    ewdata = 32'h0;
    eload = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ewdata = ewdata | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      if (i >= base && i < base + n) emask = emask | 8'(1 << i);
    end
    for (int j = 0; j < n; j++)
      eload = eload | (((rd >> (8 * (base + j))) & 32'hFF) << (8 * j));
    if (!uns && n < 4 && eload[8*n-1]) eload = eload | (32'hFFFF_FFFF << (8 * n));
  endtask

  task automatic run_txn(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns, input logic [31:0] rd,
                         input int req_d, input int resp_d, input int out_d);
    logic [31:0] ewdata, eload, erd;
    logic [7:0]  emask;
    bit          trap, tmo;
    int          guard, cycles;
    model(a, wd, sz, uns, rd, ewdata, emask, eload, trap);
    tmo = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_addr = a; in_wen = wen; in_wdata = wd; in_size = sz; in_unsigned = uns;
    tick();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    if (trap) begin
      check("trap_no_req", 32'(mem_req_valid), 32'd0);
    end else begin
      for (int k = 0; k <= req_d; k++) begin
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_in_ready", 32'(in_ready), 32'd0);
        check("req_addr", mem_addr, {a[31:2], 2'b00});
        check("req_wen", 32'(mem_wen), 32'(wen));
        check("req_wmask", 32'(mem_wmask), wen ? 32'(emask) : 32'd0);
        if (wen) check("req_wdata", mem_wdata, ewdata);
        if (k == req_d) mem_req_ready = 1'b1;
        tick();
      end
      mem_req_ready = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 64) begin
        mem_resp_valid = (cycles == resp_d);
        mem_resp_rdata = (cycles == resp_d) ? rd : $urandom;
        tick();
        cycles++;
      end
      mem_resp_valid = 1'b0;
      tmo = (resp_d >= int'(TMO));
      check("wait_cycles", 32'(cycles), tmo ? 32'(TMO) : 32'(resp_d + 1));
    end
    erd = (trap || tmo || wen) ? 32'h0 : eload;
    for (int k = 0; k <= out_d; k++) begin
      check("resp_valid", 32'(out_valid), 32'd1);
      check("resp_in_ready", 32'(in_ready), 32'd0);
      check("resp_rdata", out_rdata, erd);
      check("resp_fault", 32'(out_fault), 32'(trap || tmo));
      if (k == out_d) out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_addr = 32'h0; in_wen = 1'b0; in_wdata = 32'h0; in_size = 2'd0;
    in_unsigned = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Sign/zero extended byte load, minimum latency
    run_txn(32'h8000_0003, 1'b0, 32'h0, 2'd0, 1'b0, 32'h80FF_1234, 0, 0, 0);
    run_txn(32'h8000_0003, 1'b0, 32'h0, 2'd0, 1'b1, 32'h80FF_1234, 0, 0, 0);
    // Half store with lane replication
    run_txn(32'h8000_0002, 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b0, 32'h5555_AAAA, 0, 1, 0);
    // Backpressure on both sides
    run_txn(32'h4000_0010, 1'b1, 32'h0BAD_F00D, 2'd2, 1'b0, 32'h0, 5, 2, 3);
    // Timeout, then a stray response in IDLE
    run_txn(32'h2000_0004, 1'b0, 32'h0, 2'd2, 1'b0, 32'h1111_2222, 0, 20, 0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_out_valid", 32'(out_valid), 32'd0);
    check("stray_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    check("stray_in_ready", 32'(in_ready), 32'd1);
    // Misaligned word load
    run_txn(32'h8000_0001, 1'b0, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0, 0);
    run_txn(32'h8000_0003, 1'b1, 32'h1234_5678, 2'd1, 1'b0, 32'h0, 0, 0, 0);

    // Reset in the middle of WAIT
    in_valid = 1'b1; in_addr = 32'h1000; in_wen = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("mid_rst_addr", mem_addr, 32'h0);
    check("mid_rst_rdata", out_rdata, 32'h0);
    tick();
    rst = 1'b0;
    run_txn(32'h0000_1000, 1'b0, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 0);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      int rdl;
      rdl = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
      run_txn($urandom, 1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), rdl, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit sitting between the execute stage and the data-memory port.
- Takes one load/store per handshake, builds a word-aligned memory request (address, byte-lane write data, 8-bit write mask), and waits for the memory response.
- Aligns and sign- or zero-extends load data, then returns the result to writeback over a valid/ready handshake.
- One transaction outstanding at a time.

Parameters:
TIMEOUT, 1024, cycles allowed in WAIT before the access is aborted with fault; 0 disables the timeout.
CNT_W, 11, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request from execute stage
in_ready  out  1  LSU can accept a request
in_addr  in  32  byte address
in_wen  in  1  1 = store, 0 = load
in_wdata  in  32  store data, right-justified
in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
in_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts the result
out_rdata  out  32  extended load data; 0 for stores
out_fault  out  1  access aborted (timeout, or misaligned with macro)
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_addr  out  32  {in_addr[31:2], 2'b00}
mem_wen  out  1  write enable
mem_wdata  out  32  lane-shifted store data
mem_wmask  out  8  byte mask; bits [7:4] always 0
mem_resp_valid  in  1  response/ack, one cycle pulse
mem_resp_rdata  in  32  raw word read data

Behaviour:
Reset:
- Asynchronous reset, active-high, single clock clk.
- Reset forces IDLE. All outputs are 0, including in_ready while rst is high.
- Reset mid-transaction abandons the access. A later stray mem_resp_valid is ignored in IDLE.

State machine: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. When in_valid=1, latch addr, wen, size, unsigned and data; go to REQ.
- REQ: mem_req_valid=1 and request fields held stable. When mem_req_ready=1, go to WAIT and clear the counter. mem_resp_valid in REQ is ignored.
- WAIT: when mem_resp_valid=1, capture the extended data (loads) or 0 (stores), set out_fault=0, go to RESP. Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, set out_fault=1 and out_rdata=0, go to RESP.
- RESP: out_valid=1 with out_rdata/out_fault stable. When out_ready=1, go to IDLE. No new request is accepted in the same cycle.

Latency and throughput:
- Minimum latency: accept at cycle 0, REQ at cycle 1, response at cycle 2, out_valid at cycle 3.
- Best-case throughput: 1 access per 4 cycles.

Lane rules (off = in_addr[1:0]):
- Byte: mask = 1<<off; wdata = in_wdata[7:0] replicated to every byte lane.
- Half: offh = {off[1],0}; mask = 3<<offh; wdata = in_wdata[15:0] replicated to both halves.
- Word: mask = 0xF; wdata = in_wdata.
- Loads: mem_wen=0, mem_wmask=0.
- Load data: shift mem_resp_rdata right by 8*off (8*offh for half; no shift for word), then extend per in_size and in_unsigned.
- Without the macro, misaligned halves and words are silently aligned down.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, issues no memory request. IDLE goes directly to RESP with out_fault=1 and out_rdata=0.
- Undefined: accesses are aligned down as above. out_fault asserts only on timeout.

Test Plan:
- Load byte, addr 0x8000_0003, resp 0x80FF_1234 -> out_rdata 0xFFFF_FF80 at 3 cycles after accept. Same access with in_unsigned=1 -> 0x0000_0080.
- Store half, addr 0x8000_0002, in_wdata 0xDEAD_BEEF -> mem_addr 0x8000_0000, mem_wmask 0x0C, mem_wdata 0xBEEF_BEEF; after ack, out_rdata 0, out_fault 0.
- mem_req_ready held low 5 cycles, then out_ready held low 3 cycles -> request fields stable throughout, out_valid held, in_ready=0 until the RESP handshake.
- TIMEOUT=8, no response -> out_fault=1 and out_rdata=0 after 8 WAIT cycles. A response arriving later in IDLE is ignored.
- Macro defined, load word at 0x8000_0001 -> no mem_req_valid, out_fault=1. Macro undefined -> mem_addr 0x8000_0000, mask 0, full word returned.
- rst asserted mid-WAIT -> outputs 0 immediately. After release, a load word at 0x1000 completes normally with resp 0x1234_5678 -> out_rdata 0x1234_5678.
